// File: rtl/conv_window_stream.sv
`default_nettype none
// conv_window_stream -- streaming KxK convolution over raster pixels with owned line buffers,
// stride decimation and saturating, optionally rectified per-channel outputs. Rev 1.0
module conv_window_stream #(
  parameter int WidthIn     = 1,
  parameter int WidthOut    = 16,
  parameter int KernelWidth = 3,
  parameter int WeightWidth = 2,
  parameter int OutChannels = 2,
  parameter int FrameWidth  = 64,
  parameter int FrameHeight = 48,
  parameter int Stride      = 1,
  parameter int ReluEn      = 0
) (
  input  logic                                                       clk_i,
  input  logic                                                       rst_ni,
  input  logic [OutChannels*KernelWidth*KernelWidth*WeightWidth-1:0] weights_i,
  input  logic [WidthIn-1:0]                                         data_i,
  input  logic                                                       valid_i,
  output logic                                                       ready_o,
  output logic [OutChannels*WidthOut-1:0]                            data_o,
  output logic                                                       valid_o,
  input  logic                                                       ready_i,
  output logic                                                       last_o
);

  localparam int KernelArea = KernelWidth * KernelWidth;
  localparam int AccW       = WidthIn + WeightWidth + 1 + $clog2(KernelArea);
  localparam int SatW       = AccW + WidthOut;
  localparam int ColW       = (FrameWidth > 1) ? $clog2(FrameWidth) : 1;
  localparam int RowW       = (FrameHeight > 1) ? $clog2(FrameHeight) : 1;
  localparam int PhW        = (Stride > 1) ? $clog2(Stride) : 1;
  localparam int LastRowI   = KernelWidth - 1 + ((FrameHeight - KernelWidth) / Stride) * Stride;
  localparam int LastColI   = KernelWidth - 1 + ((FrameWidth - KernelWidth) / Stride) * Stride;

  localparam logic [ColW-1:0] ColMax  = ColW'(FrameWidth - 1);
  localparam logic [RowW-1:0] RowMax  = RowW'(FrameHeight - 1);
  localparam logic [ColW-1:0] ColWarm = ColW'(KernelWidth - 1);
  localparam logic [RowW-1:0] RowWarm = RowW'(KernelWidth - 1);
  localparam logic [ColW-1:0] ColLast = ColW'(LastColI);
  localparam logic [RowW-1:0] RowLast = RowW'(LastRowI);
  localparam logic [PhW-1:0]  PhMax   = PhW'(Stride - 1);

  localparam logic signed [SatW-1:0] SatMax = {{(SatW-WidthOut+1){1'b0}}, {(WidthOut-1){1'b1}}};
  localparam logic signed [SatW-1:0] SatMin = {{(SatW-WidthOut+1){1'b1}}, {(WidthOut-1){1'b0}}};

  logic [ColW-1:0]    col;
  logic [RowW-1:0]    row;
  logic [PhW-1:0]     col_ph;
  logic [PhW-1:0]     row_ph;
  logic [WidthIn-1:0] linebuf [KernelWidth-1][FrameWidth];
  logic [WidthIn-1:0] win     [KernelWidth][KernelWidth];
  logic [WidthIn-1:0] win_nxt [KernelWidth][KernelWidth];
  logic [OutChannels*WidthOut-1:0] mac;
  logic fire;
  logic emit;
  logic at_last;

  assign ready_o = !valid_o | ready_i;
  assign fire    = valid_i & ready_o;
  // Phase counters stay at 0 during warm-up, so a zero phase past warm-up marks a stride hit.
  assign emit    = (row >= RowWarm) && (col >= ColWarm) && (row_ph == '0) && (col_ph == '0);
  assign at_last = (row == RowLast) && (col == ColLast);

  always_comb begin
    for (int r = 0; r < KernelWidth; r++) begin
      for (int c = 0; c < KernelWidth - 1; c++) begin
        win_nxt[r][c] = win[r][c+1];
      end
    end
    for (int r = 0; r < KernelWidth - 1; r++) begin
      win_nxt[r][KernelWidth-1] = linebuf[KernelWidth-2-r][col];
    end
    win_nxt[KernelWidth-1][KernelWidth-1] = data_i;
  end

  for (genvar ch = 0; ch < OutChannels; ch++) begin : g_ch
    logic signed [AccW-1:0]        acc;
    logic signed [SatW-1:0]        acc_ext;
    logic signed [WidthOut-1:0]    res;
    logic signed [WeightWidth-1:0] w;
    always_comb begin
      acc = '0;
      w   = '0;
      for (int r = 0; r < KernelWidth; r++) begin
        for (int c = 0; c < KernelWidth; c++) begin
          w   = weights_i[(ch*KernelArea + r*KernelWidth + c)*WeightWidth +: WeightWidth];
          acc = acc + $signed({{(AccW-WidthIn){1'b0}}, win_nxt[r][c]}) * AccW'(w);
        end
      end
      acc_ext = SatW'(acc);
      if (acc_ext > SatMax)      res = SatMax[WidthOut-1:0];
      else if (acc_ext < SatMin) res = SatMin[WidthOut-1:0];
      else                       res = acc_ext[WidthOut-1:0];
      if (ReluEn != 0 && res < 0) res = '0;
    end
    assign mac[ch*WidthOut +: WidthOut] = res;
  end

  // Line buffers carry no reset; warm-up gating keeps stale entries out of any emitted window.
  always_ff @(posedge clk_i) begin
    if (fire) begin
      linebuf[0][col] <= data_i;
      for (int i = 1; i < KernelWidth - 1; i++) begin
        linebuf[i][col] <= linebuf[i-1][col];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col     <= '0;
      row     <= '0;
      col_ph  <= '0;
      row_ph  <= '0;
      valid_o <= 1'b0;
      data_o  <= '0;
      last_o  <= 1'b0;
      for (int r = 0; r < KernelWidth; r++) begin
        for (int c = 0; c < KernelWidth; c++) begin
          win[r][c] <= '0;
        end
      end
    end else begin
      if (fire) begin
        win <= win_nxt;
        if (col == ColMax) begin
          col    <= '0;
          col_ph <= '0;
          if (row == RowMax) begin
            row    <= '0;
            row_ph <= '0;
          end else begin
            row    <= row + 1'b1;
            row_ph <= (row < RowWarm || row_ph == PhMax) ? '0 : row_ph + 1'b1;
          end
        end else begin
          col    <= col + 1'b1;
          col_ph <= (col < ColWarm || col_ph == PhMax) ? '0 : col_ph + 1'b1;
        end
      end
      if (fire && emit) begin
        data_o  <= mac;
        valid_o <= 1'b1;
        last_o  <= at_last;
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
